// File: rtl/pwm_timer_core.sv
// Free-running single-channel PWM: period 2^BITS clocks, output high while the
// counter exceeds a threshold that is only re-sampled at the period wrap.
module pwm_timer_core #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] threshold,
    output logic            pwm_pulse
);

    localparam logic [BITS-1:0] MAX_CNT = '1;

    logic [BITS-1:0] r_cnt;
    logic [BITS-1:0] r_thr_act;
    logic            r_pwm;
    logic            w_wrap;

    assign w_wrap = (r_cnt == MAX_CNT);

    // Reset drives the output high so the active-low LED stays dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_thr_act <= threshold;
            r_pwm     <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_pwm <= (r_cnt > r_thr_act);
            if (w_wrap) begin
                r_thr_act <= threshold;
            end
        end
    end

    assign pwm_pulse = r_pwm;

endmodule

// File: tb/tb_pwm_timer_core.sv
// Directed bench for pwm_timer_core: a BITS=3 instance for reset, extremes and
// mid-period behaviour, and a BITS=7 instance for the full threshold sweep.
module tb_pwm_timer_core;

    logic       clk = 1'b0;
    logic       rst3;
    logic [2:0] thr3;
    logic       pwm3;
    logic       rst7;
    logic [6:0] thr7;
    logic       pwm7;

    int n_pass  = 0;
    int n_total = 0;
    int highs;

    always #5 clk = ~clk;

    pwm_timer_core #(.BITS(3)) u3 (
        .clk       (clk),
        .reset     (rst3),
        .threshold (thr3),
        .pwm_pulse (pwm3)
    );

    pwm_timer_core #(.BITS(7)) u7 (
        .clk       (clk),
        .reset     (rst7),
        .threshold (thr7),
        .pwm_pulse (pwm7)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst3 = 1'b1;
        thr3 = 3'd3;
        rst7 = 1'b1;
        thr7 = 7'd0;

        // Reset hold, threshold 3
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_pwm", int'(pwm3), 1);
        end
        rst3 = 1'b0;
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("thr3_k%0d", k), int'(pwm3), ((k % 8) > 3) ? 1 : 0);
            if (k >= 8) highs += int'(pwm3);
        end
        check("thr3_highs_per_period", highs, 4);

        // Extreme: threshold 7 never goes high
        rst3 = 1'b1;
        thr3 = 3'd7;
        tick();
        check("reset_thr7_pwm", int'(pwm3), 1);
        rst3 = 1'b0;
        highs = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            highs += int'(pwm3);
        end
        check("thr7_highs_3_periods", highs, 0);

        // Extreme: threshold 0 gives 7 high, 1 low
        rst3 = 1'b1;
        thr3 = 3'd0;
        tick();
        rst3 = 1'b0;
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("thr0_k%0d", k), int'(pwm3), ((k % 8) > 0) ? 1 : 0);
            if (k >= 8) highs += int'(pwm3);
        end
        check("thr0_highs_per_period", highs, 7);

        // Mid-period change 2 -> 6 while cnt is 3
        rst3 = 1'b1;
        thr3 = 3'd2;
        tick();
        rst3 = 1'b0;
        highs = 0;
        for (int k = 0; k < 21; k++) begin
            tick();
            if (k < 8)
                check($sformatf("mid_k%0d", k), int'(pwm3), (k > 2) ? 1 : 0);
            else
                check($sformatf("mid_k%0d", k), int'(pwm3), ((k % 8) > 6) ? 1 : 0);
            if (k == 2) begin
                check("mid_cnt_at_change", int'(u3.r_cnt), 3);
                thr3 = 3'd6;
            end
            if (k == 7) begin
                check("mid_period0_highs", highs + int'(pwm3), 5);
                highs = 0;
            end else begin
                highs += int'(pwm3);
            end
            if (k == 15) begin
                check("mid_period1_highs", highs, 1);
            end
        end

        // Reset in the middle of a period (cnt = 5)
        check("midrst_cnt_before", int'(u3.r_cnt), 5);
        rst3 = 1'b1;
        thr3 = 3'd4;
        tick();
        check("midrst_pwm", int'(pwm3), 1);
        check("midrst_cnt", int'(u3.r_cnt), 0);
        check("midrst_thr_act", int'(u3.r_thr_act), 4);
        rst3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("midrst_k%0d", k), int'(pwm3), (k > 4) ? 1 : 0);
        end

        // BITS=7 sweep, each threshold held for 2 periods
        tick();
        check("sweep_reset_pwm", int'(pwm7), 1);
        rst7 = 1'b0;
        for (int t = 0; t < 128; t++) begin
            thr7 = 7'(t);
            for (int k = 0; k < 128; k++) tick();
            highs = 0;
            for (int k = 0; k < 128; k++) begin
                tick();
                highs += int'(pwm7);
            end
            check($sformatf("sweep_thr%0d", t), highs, 127 - t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
